// File: rtl/ifetch_axi_bridge.sv
// ifetch_axi_bridge: instruction-fetch bridge from the core fetch port to a 64-bit AXI4-Lite read channel
//   clock, reset    : rising-edge clock, synchronous active-high reset
//   if_valid/if_addr: fetch request, held stable until if_ready
//   if_ready        : one-cycle pulse qualifying if_data_read/if_err
//   if_data_read    : registered 32-bit instruction
//   if_err          : misaligned PC or AXI error response
//   flush           : invalidate the doubleword line buffer
//   araddr/arvalid/arready : AXI read address channel (address aligned to 8 bytes)
//   rdata/rresp/rvalid/rready : AXI read data channel
module ifetch_axi_bridge #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int INST_WIDTH = 32,
  parameter int BUF_EN     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [INST_WIDTH-1:0] if_data_read,
  output logic                  if_err,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);
  typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;
  state_t r_state, w_next;
  logic                  r_lane;
  logic                  r_no_fill;
  logic                  r_buf_valid;
  logic [ADDR_WIDTH-4:0] r_buf_tag;
  logic [DATA_WIDTH-1:0] r_buf_data;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [INST_WIDTH-1:0] r_data;
  logic                  r_err;
  logic                  w_misaligned;
  logic                  w_hit;
  logic                  w_beat;
  logic                  w_ok;
  logic                  w_fill;
  assign w_misaligned = if_valid && (if_addr[1:0] != 2'b00);
  assign w_hit        = if_valid && r_buf_valid && (r_buf_tag == if_addr[ADDR_WIDTH-1:3]) && !flush;
  assign w_beat       = (r_state == R) && rvalid;
  assign w_ok         = (rresp == 2'b00);
  // a flush seen while the read was in flight, or in the fill cycle itself, keeps stale data out of the buffer
  assign w_fill       = (BUF_EN != 0) && w_beat && w_ok && !r_no_fill && !flush;
  assign araddr       = r_araddr;
  assign if_data_read = r_data;
  assign if_err       = r_err;
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_comb begin
    w_next   = r_state;
    arvalid  = 1'b0;
    rready   = 1'b0;
    if_ready = 1'b0;
    unique case (r_state)
      IDLE: w_next = !if_valid ? IDLE : (w_misaligned || w_hit) ? RESP : AR;
      AR: begin
        arvalid = 1'b1;
        w_next  = arready ? R : AR;
      end
      R: begin
        rready = 1'b1;
        w_next = rvalid ? RESP : R;
      end
      default: begin
        if_ready = 1'b1;
        w_next   = IDLE;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lane      <= 1'b0;
      r_no_fill   <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf_tag   <= '0;
      r_buf_data  <= '0;
      r_araddr    <= '0;
      r_data      <= '0;
      r_err       <= 1'b0;
    end else begin
      if (r_state == IDLE && if_valid) begin
        if (w_misaligned) begin
          r_err  <= 1'b1;
          r_data <= '0;
        end else if (w_hit) begin
          r_err  <= 1'b0;
          r_data <= if_addr[2] ? r_buf_data[2*INST_WIDTH-1:INST_WIDTH] : r_buf_data[INST_WIDTH-1:0];
        end else begin
          r_araddr  <= {if_addr[ADDR_WIDTH-1:3], 3'b000};
          r_lane    <= if_addr[2];
          r_no_fill <= 1'b0;
        end
      end
      if ((r_state == AR || r_state == R) && flush) r_no_fill <= 1'b1;
      if (w_beat) begin
        r_err  <= !w_ok;
        r_data <= !w_ok ? '0 : r_lane ? rdata[2*INST_WIDTH-1:INST_WIDTH] : rdata[INST_WIDTH-1:0];
      end
      if (w_fill) begin
        r_buf_data <= rdata;
        r_buf_tag  <= r_araddr[ADDR_WIDTH-1:3];
      end
      r_buf_valid <= (flush || (w_beat && !w_ok)) ? 1'b0 : w_fill ? 1'b1 : r_buf_valid;
    end
  end
endmodule

// File: tb/tb_ifetch_axi_bridge.sv
// tb_ifetch_axi_bridge: directed and randomized checks of the fetch bridge against a line-buffer reference model
module tb_ifetch_axi_bridge;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_valid = 1'b0;
  logic [63:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_data_read;
  logic        if_err;
  logic        flush = 1'b0;
  logic [63:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  int checks = 0;
  int errors = 0;
  bit          m_valid;
  logic [60:0] m_tag;
  logic [63:0] m_data;
  always #5 clock = ~clock;
  ifetch_axi_bridge dut (
    .clock(clock), .reset(reset), .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready),
    .if_data_read(if_data_read), .if_err(if_err), .flush(flush), .araddr(araddr), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );
  // core + memory driver; mode 0 none, 1 flush in the sampling cycle, 2 flush in the first R cycle
  task automatic fetch(input logic [63:0] addr, input int mode, input int aw, input int rw,
                       input logic [1:0] resp, input logic [63:0] data,
                       output logic [31:0] d, output logic e, output int lat, output int n_ar,
                       output logic [63:0] ar_a, output logic rdy_after);
    int ac = 0;
    int rc = 0;
    d = '0; e = 1'b0; lat = -1; n_ar = 0; ar_a = '0;
    if_valid = 1'b1; if_addr = addr; flush = (mode == 1);
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      @(negedge clock);
      flush = 1'b0; arready = 1'b0; rvalid = 1'b0;
      if (arvalid) begin
        arready = (ac >= aw);
        if (arready) begin n_ar++; ar_a = araddr; end
        ac++;
      end
      if (rready) begin
        flush = (mode == 2 && rc == 0);
        rvalid = (rc >= rw); rdata = data; rresp = resp;
        rc++;
      end
      if (if_ready) begin lat = c; d = if_data_read; e = if_err; end
    end
    if_valid = 1'b0; arready = 1'b0; rvalid = 1'b0; flush = 1'b0;
    @(negedge clock);
    rdy_after = if_ready;
  endtask
  // reference: a single doubleword line, misaligned faults, miss cost 3 + handshake waits
  task automatic predict(input logic [63:0] addr, input int mode, input int aw, input int rw,
                         input logic [1:0] resp, input logic [63:0] data,
                         output logic [31:0] d, output logic e, output int lat, output int n_ar,
                         output logic [63:0] ar_a);
    n_ar = 0; ar_a = '0; e = 1'b0; d = '0; lat = 1;
    if (mode == 1) m_valid = 0;
    if (addr[1:0] != 2'b00) e = 1'b1;
    else if (m_valid && m_tag == addr[63:3]) d = addr[2] ? m_data[63:32] : m_data[31:0];
    else begin
      n_ar = 1; ar_a = addr & ~64'h7; lat = 3 + aw + rw;
      if (resp != 2'b00) begin
        e = 1'b1; m_valid = 0;
      end else begin
        d = addr[2] ? data[63:32] : data[31:0];
        m_valid = (mode != 2); m_tag = addr[63:3]; m_data = data;
      end
    end
  endtask
  task automatic test_reset;
    reset = 1'b1; arready = 1'b1; rvalid = 1'b1; if_valid = 1'b1; if_addr = 64'h8000_0000;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if ({if_ready, arvalid, rready, if_err, if_data_read} !== 36'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: rdy=%b arv=%b rrdy=%b err=%b data=%h, required all 0", i, if_ready, arvalid, rready, if_err, if_data_read);
      end
    end
    reset = 1'b0; arready = 1'b0; rvalid = 1'b0; if_valid = 1'b0;
    @(negedge clock);
  endtask
  task automatic test_miss_low;
    logic [31:0] d; logic e, ra; int lat, n; logic [63:0] a;
    fetch(64'h8000_0000, 0, 2, 3, 2'b00, 64'h00100073_00000413, d, e, lat, n, a, ra);
    checks += 5;
    if (n !== 1 || a !== 64'h8000_0000) begin errors++; $display("FAIL miss_ar: count=%0d addr=%h, required 1 and 80000000", n, a); end
    if (d !== 32'h0000_0413) begin errors++; $display("FAIL miss_data: got %h, required 00000413", d); end
    if (e !== 1'b0) begin errors++; $display("FAIL miss_err: got %b, required 0", e); end
    if (lat != 8) begin errors++; $display("FAIL miss_latency: got %0d, required 8", lat); end
    if (ra !== 1'b0) begin errors++; $display("FAIL miss_pulse: if_ready still %b after pulse, required 0", ra); end
  endtask
  task automatic test_hit;
    logic [31:0] d; logic e, ra; int lat, n; logic [63:0] a;
    fetch(64'h8000_0004, 0, 0, 0, 2'b00, 64'h5555_5555_6666_6666, d, e, lat, n, a, ra);
    checks += 3;
    if (n !== 0) begin errors++; $display("FAIL hit_no_ar: got %0d AR handshakes, required 0", n); end
    if (d !== 32'h0010_0073 || e !== 1'b0) begin errors++; $display("FAIL hit_data: got %h err=%b, required 00100073 err=0", d, e); end
    if (lat != 1 || ra !== 1'b0) begin errors++; $display("FAIL hit_latency: got %0d pulse_after=%b, required 1 and 0", lat, ra); end
  endtask
  task automatic test_flush;
    logic [31:0] d; logic e, ra; int lat, n; logic [63:0] a;
    fetch(64'h8000_0004, 1, 1, 0, 2'b00, 64'hDEAD_BEEF_1234_5678, d, e, lat, n, a, ra);
    checks += 2;
    if (n !== 1 || a !== 64'h8000_0000) begin errors++; $display("FAIL flush_ar: count=%0d addr=%h, required 1 and 80000000", n, a); end
    if (d !== 32'hDEAD_BEEF || lat != 4) begin errors++; $display("FAIL flush_data: got %h lat=%0d, required deadbeef lat=4", d, lat); end
    fetch(64'h8000_0010, 2, 0, 1, 2'b00, 64'hCAFE_F00D_0BAD_C0DE, d, e, lat, n, a, ra);
    checks++;
    if (d !== 32'h0BAD_C0DE || n !== 1) begin errors++; $display("FAIL inflight_flush_data: got %h ar=%0d, required 0badc0de ar=1", d, n); end
    fetch(64'h8000_0014, 0, 0, 0, 2'b00, 64'h1111_1111_2222_2222, d, e, lat, n, a, ra);
    checks++;
    if (n !== 1 || d !== 32'h1111_1111) begin errors++; $display("FAIL inflight_flush_nofill: ar=%0d data=%h, required ar=1 data=11111111", n, d); end
  endtask
  task automatic test_error;
    logic [31:0] d; logic e, ra; int lat, n; logic [63:0] a;
    fetch(64'h8000_0008, 0, 0, 0, 2'b10, 64'hAAAA_AAAA_BBBB_BBBB, d, e, lat, n, a, ra);
    checks++;
    if (e !== 1'b1 || d !== 32'd0) begin errors++; $display("FAIL error_resp: err=%b data=%h, required err=1 data=0", e, d); end
    fetch(64'h8000_000C, 0, 0, 0, 2'b00, 64'h3333_3333_4444_4444, d, e, lat, n, a, ra);
    checks++;
    if (n !== 1 || d !== 32'h3333_3333 || e !== 1'b0) begin errors++; $display("FAIL error_nofill: ar=%0d data=%h err=%b, required ar=1 data=33333333 err=0", n, d, e); end
  endtask
  task automatic test_misaligned;
    logic [31:0] d; logic e, ra; int lat, n; logic [63:0] a;
    fetch(64'h8000_0002, 0, 0, 0, 2'b00, 64'h7777_7777_7777_7777, d, e, lat, n, a, ra);
    checks++;
    if (e !== 1'b1 || d !== 32'd0 || lat != 1 || n !== 0) begin errors++; $display("FAIL misaligned: err=%b data=%h lat=%0d ar=%0d, required 1 0 1 0", e, d, lat, n); end
  endtask
  task automatic test_reset_mid_r;
    logic [31:0] d; logic e, ra; int lat, n; logic [63:0] a;
    bit seen = 0;
    fetch(64'h8000_0010, 0, 0, 0, 2'b00, 64'h9999_9999_8888_8888, d, e, lat, n, a, ra);
    if_valid = 1'b1; if_addr = 64'h8000_0018;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      arready = arvalid;
      seen = rready;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL reset_mid_r_reach: rready never rose, required 1"); end
    reset = 1'b1; if_valid = 1'b0; arready = 1'b0;
    @(negedge clock);
    checks++;
    if ({rready, arvalid, if_ready, if_err, if_data_read} !== 36'd0) begin errors++; $display("FAIL reset_mid_r: rrdy=%b arv=%b rdy=%b err=%b data=%h, required all 0", rready, arvalid, if_ready, if_err, if_data_read); end
    reset = 1'b0;
    fetch(64'h8000_0014, 0, 0, 0, 2'b00, 64'h1234_0000_5678_0000, d, e, lat, n, a, ra);
    checks++;
    if (n !== 1 || d !== 32'h1234_0000) begin errors++; $display("FAIL reset_clears_buf: ar=%0d data=%h, required ar=1 data=12340000", n, d); end
  endtask
  task automatic test_random;
    logic [31:0] d, xd; logic e, xe, ra; int lat, xlat, n, xn; logic [63:0] a, xa, addr, data;
    int mode, aw, rw; logic [1:0] resp;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0; m_valid = 0;
    for (int i = 0; i < 60; i++) begin
      addr = 64'h8000_0000 + 64'(($urandom_range(0, 7) * 4) + ($urandom_range(0, 9) == 0 ? 2 : 0));
      mode = $urandom_range(0, 5);
      if (mode > 2) mode = 0;
      aw = $urandom_range(0, 3); rw = $urandom_range(0, 3);
      resp = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
      data = {$urandom, $urandom};
      predict(addr, mode, aw, rw, resp, data, xd, xe, xlat, xn, xa);
      fetch(addr, mode, aw, rw, resp, data, d, e, lat, n, a, ra);
      checks++;
      if (d !== xd || e !== xe || lat != xlat || n != xn || a !== xa || ra !== 1'b0) begin
        errors++;
        $display("FAIL random[%0d] addr=%h mode=%0d: data=%h err=%b lat=%0d ar=%0d araddr=%h after=%b, required data=%h err=%b lat=%0d ar=%0d araddr=%h after=0",
                 i, addr, mode, d, e, lat, n, a, ra, xd, xe, xlat, xn, xa);
      end
    end
  endtask
  initial begin
    test_reset;
    test_miss_low;
    test_hit;
    test_flush;
    test_error;
    test_misaligned;
    test_reset_mid_r;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
